multu_seq: RTL and testbench

MULTU_SEQ -- requirements
Module: multu_seq

---
 rtl/multu_pkg.sv | 18 +
 rtl/multu_seq.sv | 137 +++++++++++++
 tb/tb_multu_seq.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/multu_pkg.sv
// Shared definitions for the sequential unsigned multiplier (multu_seq).
// Provides the controller state enum, the default operand width and a counter sizing helper.
package multu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } multuState_e;

  localparam int MULTU_WIDTH = 32;

  // Step counter must reach WIDTH-1, so one spare bit keeps any WIDTH safe.
  function automatic int multuCountBits(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/multu_seq.sv
// Shift-and-add unsigned multiplier, one multiplier bit per RUN cycle, registered outputs.
// Optional macro MULTU_EARLY_EXIT_EN ends RUN as soon as the remaining multiplier bits are all zero.
module multu_seq
  import multu_pkg::*;
#(
  parameter int WIDTH = MULTU_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 acc_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   MultuAns,
  output logic                 HL
);

  localparam int CW = multuCountBits(WIDTH);

  multuState_e          state_r;
  multuState_e          nextState_s;
  logic [2*WIDTH-1:0]   mcand_r;
  logic [2*WIDTH-1:0]   product_r;
  logic [2*WIDTH-1:0]   sum_s;
  logic [WIDTH-1:0]     mplier_r;
  logic [CW-1:0]        count_r;
  logic                 accReq_r;
  logic                 accept_s;
  logic                 lastStep_s;

  // Next-state decode, start acceptance and the per-step partial-product add.
  always_comb begin
    nextState_s = state_r;
    accept_s    = 1'b0;
    lastStep_s  = 1'b0;
    sum_s       = product_r;
    if (mplier_r[0]) begin
      sum_s = product_r + mcand_r;
    end else begin
      sum_s = product_r;
    end
`ifdef MULTU_EARLY_EXIT_EN
    lastStep_s = (count_r == CW'(WIDTH - 1)) || ((mplier_r >> 1'b1) == {WIDTH{1'b0}});
`else
    lastStep_s = (count_r == CW'(WIDTH - 1));
`endif
    case (state_r)
      IDLE: begin
        if (start) begin
          accept_s    = 1'b1;
          nextState_s = RUN;
        end else begin
          nextState_s = IDLE;
        end
      end
      RUN: begin
        if (lastStep_s) begin
          nextState_s = DONE;
        end else begin
          nextState_s = RUN;
        end
      end
      DONE: begin
        // Back-to-back start skips IDLE entirely.
        if (start) begin
          accept_s    = 1'b1;
          nextState_s = RUN;
        end else begin
          nextState_s = IDLE;
        end
      end
      default: begin
        nextState_s = IDLE;
      end
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Operand capture on accept, shift-and-add datapath while running.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_r   <= {(2*WIDTH){1'b0}};
      mplier_r  <= {WIDTH{1'b0}};
      product_r <= {(2*WIDTH){1'b0}};
      count_r   <= {CW{1'b0}};
      accReq_r  <= 1'b0;
    end else if (accept_s) begin
      mcand_r   <= {{WIDTH{1'b0}}, a};
      mplier_r  <= b;
      product_r <= {(2*WIDTH){1'b0}};
      count_r   <= {CW{1'b0}};
      accReq_r  <= acc_in;
    end else if (state_r == RUN) begin
      product_r <= sum_s;
      mcand_r   <= mcand_r << 1'b1;
      mplier_r  <= mplier_r >> 1'b1;
      count_r   <= count_r + CW'(1);
    end else begin
      mcand_r   <= mcand_r;
      mplier_r  <= mplier_r;
      product_r <= product_r;
      count_r   <= count_r;
      accReq_r  <= accReq_r;
    end
  end

  // Registered status and result; result/HL only change on the final step into DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      MultuAns <= {(2*WIDTH){1'b0}};
      HL       <= 1'b0;
    end else begin
      busy <= (nextState_s == RUN);
      done <= (nextState_s == DONE);
      if ((state_r == RUN) && lastStep_s) begin
        MultuAns <= sum_s;
        HL       <= accReq_r;
      end else begin
        MultuAns <= MultuAns;
        HL       <= HL;
      end
    end
  end

endmodule

// File: tb/tb_multu_seq.sv
// Randomized scoreboard bench for multu_seq: a reference model computes product and latency
// from plain arithmetic; a negedge monitor checks done timing, result, HL, busy and held outputs.
module tb_multu_seq;

  localparam int W = 32;

  typedef struct {
    int          acc;
    int          dn;
    logic [63:0] prod;
    logic        hl;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          acc_in;
  logic          busy;
  logic          done;
  logic [2*W-1:0] MultuAns;
  logic          HL;

  int   cyc;
  int   total;
  int   bad;
  int   busyUntil;
  bit   monOn;
  logic [63:0] lastAns;
  logic        lastHL;
  exp_t expQ[$];

  multu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .acc_in(acc_in),
    .busy(busy), .done(done), .MultuAns(MultuAns), .HL(HL)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  // Reference latency: number of RUN cycles for multiplier value bv.
  function automatic int runSteps(input logic [W-1:0] bv);
`ifdef MULTU_EARLY_EXIT_EN
    int n;
    n = 1;
    for (int i = 0; i < W; i++) if (bv[i]) n = i + 1;
    return n;
`else
    return W;
`endif
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents done.
  always @(negedge clk) begin
    if (monOn) begin
      exp_t e;
      bit   expBusy;
      if (done) begin
        if (expQ.size() == 0) begin
          chk("spurious_done", 64'd1, 64'd0);
        end else begin
          e = expQ.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.dn));
          chk("product", MultuAns, e.prod);
          chk("hl", 64'(HL), 64'(e.hl));
          lastAns = e.prod;
          lastHL  = e.hl;
        end
      end else if (expQ.size() > 0 && expQ[0].dn <= cyc) begin
        e = expQ.pop_front();
        chk("missing_done", 64'd0, 64'd1);
        lastAns = e.prod;
        lastHL  = e.hl;
      end
      expBusy = 1'b0;
      foreach (expQ[i]) if (expQ[i].acc < cyc && cyc < expQ[i].dn) expBusy = 1'b1;
      chk("busy", 64'(busy), 64'(expBusy));
      chk("held_ans", MultuAns, lastAns);
      chk("held_hl", 64'(HL), 64'(lastHL));
    end
  end

  task automatic waitCycle(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive start for one cycle; the model decides acceptance from its own busy window.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic hv);
    exp_t e;
    start  = 1'b1;
    a      = av;
    b      = bv;
    acc_in = hv;
    if (cyc >= busyUntil) begin
      e.acc  = cyc;
      e.dn   = cyc + runSteps(bv) + 1;
      e.prod = {32'd0, av} * {32'd0, bv};
      e.hl   = hv;
      expQ.push_back(e);
      busyUntil = e.dn;
    end
    @(posedge clk);
    #1;
    start  = 1'b0;
    a      = $urandom;
    b      = $urandom;
    acc_in = 1'($urandom_range(0, 1));
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    expQ.delete();
    busyUntil = 0;
    lastAns   = 64'd0;
    lastHL    = 1'b0;
  endtask

  initial begin
    int c0;
    int mode;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    cyc = 0; total = 0; bad = 0; busyUntil = 0; monOn = 1'b0;
    lastAns = 64'd0; lastHL = 1'b0;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; acc_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    monOn = 1'b1;

    waitCycle(cyc + 2);
    issue(32'd3, 32'd5, 1'b0);
    waitCycle(busyUntil + 2);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    waitCycle(busyUntil + 1);

    // Start while busy must be ignored.
    c0 = cyc;
    issue(32'd7, 32'd9, 1'b0);
    waitCycle(c0 + 10);
    issue(32'd1, 32'd1, 1'b1);
    waitCycle(busyUntil + 1);

    // Reset mid-run abandons the operation.
    c0 = cyc;
    issue(32'd12345, 32'hFFFF_0001, 1'b1);
    waitCycle(c0 + 15);
    doReset();
    waitCycle(c0 + 17);
    issue(32'd11, 32'd13, 1'b1);

    // Back-to-back start in the done cycle.
    waitCycle(busyUntil);
    issue(32'd2, 32'd4, 1'b0);
    waitCycle(busyUntil + 1);

    issue(32'd0, 32'd0, 1'b1);
    waitCycle(busyUntil + 1);
    issue(32'd0, 32'hDEAD_BEEF, 1'b0);
    waitCycle(busyUntil + 1);
    issue(32'hABCD_0123, 32'd1, 1'b0);
    waitCycle(busyUntil + 1);
    issue(32'h1234_5678, 32'h8000_0000, 1'b1);
    waitCycle(busyUntil);

    for (int it = 0; it < 40; it++) begin
      mode = $urandom_range(0, 3);
      ra = $urandom;
      rb = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 255)) : W'($urandom);
      if (mode == 0) begin
        waitCycle(busyUntil);
      end else if (mode == 1) begin
        if (cyc < busyUntil - 1) issue($urandom, $urandom, 1'b1);
        waitCycle(busyUntil);
      end else begin
        waitCycle(busyUntil + $urandom_range(1, 3));
      end
      issue(ra, rb, 1'($urandom_range(0, 1)));
    end

    waitCycle(busyUntil + 3);
    chk("queue_drained", 64'(expQ.size()), 64'd0);
    monOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
